wb_byte_master: RTL and testbench

- Wishbone initiator that turns a byte-stream command protocol into single Wishbone read/write cycles and returns results as bytes.
- Sits between the UART byte receiver/transmitter and the system Wishbone bus. Lets a host poke PWM and other slave registers without the CPU.
- One outstanding bus cycle at a time, no pipelining.

---
 rtl/wb_byte_master.sv | 161 ++++++++++++++++
 tb/tb_wb_byte_master.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/wb_byte_master.sv
// Byte-stream to Wishbone bridge: opcode + 4 address bytes (+4 data bytes for writes) -> one bus cycle -> response bytes.
// Optional ack-wait timeout compiled in with WB_TIMEOUT_EN (adds TIMEOUT parameter).
module wb_byte_master #(
    parameter logic [7:0] RESP_OK  = 8'h4B,
    parameter logic [7:0] RESP_ERR = 8'h3F
`ifdef WB_TIMEOUT_EN
    , parameter int TIMEOUT = 255
`endif
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        wb_cyc_o,
    output logic        wb_stb_o,
    output logic        wb_we_o,
    output logic [31:0] wb_adr_o,
    output logic [3:0]  wb_sel_o,
    output logic [31:0] wb_dat_o,
    input  logic [31:0] wb_dat_i,
    input  logic        wb_ack_i,
    output logic        busy
);

    typedef enum logic [2:0] {S_IDLE, S_ADDR, S_DATA, S_BUS, S_RESP} state_t;

    state_t      state_q, state_d;
    logic [1:0]  cnt_q, cnt_d;
    logic        we_q, we_d;
    logic [31:0] adr_q, adr_d;
    logic [31:0] dat_q, dat_d;
    logic [31:0] resp_q, resp_d;

`ifdef WB_TIMEOUT_EN
    localparam int TW = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
    logic [TW-1:0] to_q, to_d;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= 2'd0;
            we_q    <= 1'b0;
            adr_q   <= 32'h0;
            dat_q   <= 32'h0;
            resp_q  <= 32'h0;
`ifdef WB_TIMEOUT_EN
            to_q    <= '0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            adr_q   <= adr_d;
            dat_q   <= dat_d;
            resp_q  <= resp_d;
`ifdef WB_TIMEOUT_EN
            to_q    <= to_d;
`endif
        end
    end

    // Single-byte responses start the counter at 3 so every response ends when it wraps 3->0.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        adr_d   = adr_q;
        dat_d   = dat_q;
        resp_d  = resp_q;
`ifdef WB_TIMEOUT_EN
        to_d    = to_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (rx_valid) begin
                    if (rx_data == 8'h57 || rx_data == 8'h52) begin
                        we_d    = (rx_data == 8'h57);
                        cnt_d   = 2'd0;
                        state_d = S_ADDR;
                    end else begin
                        resp_d  = {RESP_ERR, 24'h0};
                        cnt_d   = 2'd3;
                        state_d = S_RESP;
                    end
                end
            end
            S_ADDR: begin
                if (rx_valid) begin
                    adr_d = {adr_q[23:0], rx_data};
                    cnt_d = cnt_q + 2'd1;
                    if (cnt_q == 2'd3) begin
                        state_d = we_q ? S_DATA : S_BUS;
`ifdef WB_TIMEOUT_EN
                        to_d    = '0;
`endif
                    end
                end
            end
            S_DATA: begin
                if (rx_valid) begin
                    dat_d = {dat_q[23:0], rx_data};
                    cnt_d = cnt_q + 2'd1;
                    if (cnt_q == 2'd3) begin
                        state_d = S_BUS;
`ifdef WB_TIMEOUT_EN
                        to_d    = '0;
`endif
                    end
                end
            end
            S_BUS: begin
                if (wb_ack_i) begin
                    state_d = S_RESP;
                    if (we_q) begin
                        resp_d = {RESP_OK, 24'h0};
                        cnt_d  = 2'd3;
                    end else begin
                        resp_d = wb_dat_i;
                        cnt_d  = 2'd0;
                    end
                end
`ifdef WB_TIMEOUT_EN
                else if (to_q == TW'(TIMEOUT - 1)) begin
                    resp_d  = {8'h54, 24'h0};
                    cnt_d   = 2'd3;
                    state_d = S_RESP;
                end else begin
                    to_d = to_q + 1'b1;
                end
`endif
            end
            S_RESP: begin
                if (tx_ready) begin
                    resp_d = {resp_q[23:0], 8'h0};
                    cnt_d  = cnt_q + 2'd1;
                    if (cnt_q == 2'd3) begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign rx_ready = (state_q == S_IDLE) || (state_q == S_ADDR) || (state_q == S_DATA);
    assign wb_cyc_o = (state_q == S_BUS);
    assign wb_stb_o = (state_q == S_BUS);
    assign wb_we_o  = (state_q == S_BUS) && we_q;
    assign wb_adr_o = adr_q;
    assign wb_dat_o = dat_q;
    assign wb_sel_o = 4'hF;
    assign tx_valid = (state_q == S_RESP);
    assign tx_data  = resp_q[31:24];
    assign busy     = (state_q != S_IDLE);

endmodule

// File: tb/tb_wb_byte_master.sv
// Directed bench for wb_byte_master: vector table of frames, bus slave model, response scoreboard.
// Define WB_TIMEOUT_EN to also exercise the ack timeout with TIMEOUT=16.
module tb_wb_byte_master;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        wb_cyc_o, wb_stb_o, wb_we_o;
    logic [31:0] wb_adr_o, wb_dat_o, wb_dat_i;
    logic [3:0]  wb_sel_o;
    logic        wb_ack_i;
    logic        busy;

    int pass_cnt = 0;
    int total_cnt = 0;
    logic [7:0] exp_q[$];

    typedef struct {
        logic [7:0]  op;
        logic [31:0] adr;
        logic [31:0] wdat;
        logic [31:0] rdat;
        int          ack_dly;
        int          stall;
        int          nresp;
        logic [31:0] resp;
    } vec_t;

    vec_t vecs[7];

    wb_byte_master #(
        .RESP_OK(8'h4B)
`ifdef WB_TIMEOUT_EN
        , .TIMEOUT(16)
`endif
    ) dut (
        .clk(clk), .reset(reset),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o),
        .wb_adr_o(wb_adr_o), .wb_sel_o(wb_sel_o), .wb_dat_o(wb_dat_o),
        .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i), .busy(busy)
    );

    // Clock / watchdog
    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        total_cnt++;
        if (act === want) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", name, act, want);
    endtask

    task automatic fail_bound(input string name);
        total_cnt++;
        $display("FAIL %s: wait limit expired", name);
    endtask

    // Driver tasks; all are entered and left 1 time unit after a rising edge.
    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        rx_data  = b;
        rx_valid = 1'b1;
        while (!rx_ready && n < 100) begin
            @(posedge clk); #1; n++;
        end
        if (n >= 100) fail_bound("rx_ready_wait");
        @(posedge clk); #1;
        rx_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] op, input logic [31:0] adr, input logic [31:0] wdat);
        send_byte(op);
        for (int i = 0; i < 4; i++) send_byte(adr[31-8*i -: 8]);
        if (op == 8'h57)
            for (int i = 0; i < 4; i++) send_byte(wdat[31-8*i -: 8]);
    endtask

    task automatic wait_cyc(output bit ok);
        int n = 0;
        while (!wb_cyc_o && n < 50) begin
            @(posedge clk); #1; n++;
        end
        ok = (n < 50);
        if (!ok) fail_bound("cyc_wait");
    endtask

    task automatic bus_slave(input vec_t v);
        bit ok;
        wait_cyc(ok);
        if (ok) begin
            check("bus_adr", wb_adr_o, v.adr);
            check("bus_we", {31'h0, wb_we_o}, {31'h0, v.op == 8'h57});
            if (v.op == 8'h57) check("bus_dat", wb_dat_o, v.wdat);
            check("bus_sel", {28'h0, wb_sel_o}, 32'hF);
            check("bus_stb", {31'h0, wb_stb_o}, 32'h1);
            check("rx_ready_bus", {31'h0, rx_ready}, 32'h0);
            repeat (v.ack_dly) begin @(posedge clk); #1; end
            check("bus_hold", {31'h0, wb_cyc_o}, 32'h1);
            wb_dat_i = v.rdat;
            wb_ack_i = 1'b1;
            @(posedge clk); #1;
            wb_ack_i = 1'b0;
            wb_dat_i = $urandom();
            check("bus_drop", {29'h0, wb_cyc_o, wb_stb_o, wb_we_o}, 32'h0);
        end
    endtask

    task automatic recv(input int nresp, input int stall);
        int n;
        logic [7:0] want;
        for (int i = 0; i < nresp; i++) begin
            n = 0;
            while (!tx_valid && n < 50) begin
                @(posedge clk); #1; n++;
            end
            if (n >= 50) begin
                fail_bound("tx_valid_wait");
                void'(exp_q.pop_front());
            end else begin
                if (stall > 0 && i == ((nresp == 4) ? 1 : 0)) begin
                    repeat (stall) begin
                        @(posedge clk); #1;
                        check("tx_stall", {23'h0, tx_valid, tx_data}, {23'h0, 1'b1, exp_q[0]});
                        check("rx_ready_resp", {31'h0, rx_ready}, 32'h0);
                    end
                end
                tx_ready = 1'b1;
                want = exp_q.pop_front();
                check("tx_byte", {24'h0, tx_data}, {24'h0, want});
                @(posedge clk); #1;
                tx_ready = 1'b0;
            end
        end
        check("tx_done_valid", {31'h0, tx_valid}, 32'h0);
        check("done_busy", {31'h0, busy}, 32'h0);
        check("done_rx_ready", {31'h0, rx_ready}, 32'h1);
    endtask

    task automatic run_vec(input vec_t v);
        for (int i = 0; i < v.nresp; i++) exp_q.push_back(v.resp[31-8*i -: 8]);
        if (v.op == 8'h57 || v.op == 8'h52) begin
            send_frame(v.op, v.adr, v.wdat);
            bus_slave(v);
        end else begin
            send_byte(v.op);
        end
        recv(v.nresp, v.stall);
    endtask

    initial begin
        bit ok;
        int n;
        reset    = 1'b1;
        rx_data  = 8'h0;
        rx_valid = 1'b0;
        tx_ready = 1'b0;
        wb_dat_i = 32'h0;
        wb_ack_i = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        check("rst_rx_ready", {31'h0, rx_ready}, 32'h1);
        check("rst_tx_valid", {31'h0, tx_valid}, 32'h0);
        check("rst_tx_data", {24'h0, tx_data}, 32'h0);
        check("rst_bus", {29'h0, wb_cyc_o, wb_stb_o, wb_we_o}, 32'h0);
        check("rst_adr", wb_adr_o, 32'h0);
        check("rst_dat", wb_dat_o, 32'h0);
        check("rst_sel", {28'h0, wb_sel_o}, 32'hF);
        check("rst_busy", {31'h0, busy}, 32'h0);

        //         op     adr           wdat          rdat          dly stall n  resp
        vecs[0] = '{8'h57, 32'h00000008, 32'h0000007F, 32'h00000000, 2, 0, 1, 32'h4B000000};
        vecs[1] = '{8'h52, 32'h00000004, 32'h00000000, 32'h12345678, 0, 0, 4, 32'h12345678};
        vecs[2] = '{8'h52, 32'hDEADBEE0, 32'h00000000, 32'hA5C30F81, 3, 5, 4, 32'hA5C30F81};
        vecs[3] = '{8'h00, 32'h00000000, 32'h00000000, 32'h00000000, 0, 0, 1, 32'h3F000000};
        vecs[4] = '{8'h52, 32'h00000010, 32'h00000000, 32'hCAFEF00D, 1, 0, 4, 32'hCAFEF00D};
        vecs[5] = '{8'h57, 32'h80000004, 32'h01020304, 32'hFFFFFFFF, 0, 2, 1, 32'h4B000000};
        vecs[6] = '{8'hFF, 32'h00000000, 32'h00000000, 32'h00000000, 0, 3, 1, 32'h3F000000};

        for (int i = 0; i < 7; i++) run_vec(vecs[i]);

        // Reset in the middle of a bus cycle, then a late ack must be ignored.
        send_frame(8'h52, 32'h00000020, 32'h0);
        wait_cyc(ok);
        check("rstmid_stb", {31'h0, wb_stb_o}, 32'h1);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("rstmid_bus", {30'h0, wb_cyc_o, wb_stb_o}, 32'h0);
        check("rstmid_tx_valid", {31'h0, tx_valid}, 32'h0);
        check("rstmid_busy", {31'h0, busy}, 32'h0);
        check("rstmid_rx_ready", {31'h0, rx_ready}, 32'h1);
        wb_dat_i = 32'h55AA55AA;
        wb_ack_i = 1'b1;
        repeat (2) begin @(posedge clk); #1; end
        wb_ack_i = 1'b0;
        check("late_ack_tx", {31'h0, tx_valid}, 32'h0);
        check("late_ack_busy", {31'h0, busy}, 32'h0);
        run_vec(vecs[4]);

`ifdef WB_TIMEOUT_EN
        send_frame(8'h57, 32'h00000040, 32'h11223344);
        wait_cyc(ok);
        n = 0;
        while (wb_cyc_o && n < 100) begin
            n++;
            @(posedge clk); #1;
        end
        check("to_cycles", n, 32'd16);
        exp_q.push_back(8'h54);
        recv(1, 0);
`endif
        n = 0;

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
